// File: rtl/gppcu_issue_ctrl_pkg.sv
// Shared constants for the issue controller: default widths and the bit
// positions of the register fields inside an instruction word.
package gppcu_issue_ctrl_pkg;

   localparam int DEFAULT_DBW    = 32;
   localparam int DEFAULT_NUMREG = 32;
   localparam int DEFAULT_RBW    = $clog2(DEFAULT_NUMREG);
   localparam int DEFAULT_QDEPTH = 4;
   localparam int DEFAULT_NUM_WB = 2;

   // Register field positions within the default instruction word
   localparam int REGD_LSB = 21;
   localparam int REGA_LSB = 16;
   localparam int REGB_LSB = 11;

   // Per-entry field-valid flags carried alongside the payload
   typedef struct packed {
      logic use_d;
      logic use_a;
      logic use_b;
   } use_flags_t;

   // Places register numbers into their fields of a default-width word
   function automatic logic [DEFAULT_DBW-1:0] insert_fields(
      input logic [DEFAULT_DBW-1:0] base,
      input logic [DEFAULT_RBW-1:0] regd,
      input logic [DEFAULT_RBW-1:0] rega,
      input logic [DEFAULT_RBW-1:0] regb
   );
      logic [DEFAULT_DBW-1:0] w;
      w = base;
      w[REGD_LSB +: DEFAULT_RBW] = regd;
      w[REGA_LSB +: DEFAULT_RBW] = rega;
      w[REGB_LSB +: DEFAULT_RBW] = regb;
      return w;
   endfunction

endpackage

// File: rtl/gppcu_instr_fifo.sv
// Instruction queue: power-of-two circular buffer with an occupancy count
// and a flush that empties it in one edge. Ready depends only on the
// registered count, never on a same-cycle pop.
module gppcu_instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push_valid,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     push_ready,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;

   logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_fire;
   logic             pop_fire;

   assign push_ready = (count_q < CNTW'(DEPTH));
   assign empty      = (count_q == '0);
   assign push_fire  = push_valid & push_ready & ~flush;
   assign pop_fire   = pop & ~empty & ~flush;
   assign head_data  = mem_q[rd_ptr_q];
   assign count      = count_q;

   // Next pointers and count; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Storage write: accepted entry lands at the write pointer
   always_comb begin
      mem_d = mem_q;
      if (push_fire) mem_d[wr_ptr_q] = push_data;
   end

   // Pointer and count registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; stale contents are unreachable once pointers clear
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/gppcu_issue_ctrl.sv
// In-order issue controller: queues instructions, holds the head while any
// of its used registers is still pending in the scoreboard, marks the
// destination pending on issue, and clears bits on writeback.
module gppcu_issue_ctrl
   import gppcu_issue_ctrl_pkg::*;
#(
   parameter int DBW    = DEFAULT_DBW,
   parameter int QDEPTH = DEFAULT_QDEPTH,
   parameter int NUMREG = DEFAULT_NUMREG,
   parameter int NUM_WB = DEFAULT_NUM_WB
) (
   input  logic                              iACLK,
   input  logic                              iRST,
   input  logic [DBW-1:0]                    iINSTR,
   input  logic                              iINSTR_VALID,
   output logic                              oINSTR_READY,
   input  logic [$clog2(NUMREG)-1:0]         iREGD,
   input  logic [$clog2(NUMREG)-1:0]         iREGA,
   input  logic [$clog2(NUMREG)-1:0]         iREGB,
   input  logic                              iUSE_D,
   input  logic                              iUSE_A,
   input  logic                              iUSE_B,
   output logic                              oISSUE_VALID,
   output logic [DBW-1:0]                    oISSUE_INSTR,
   output logic [$clog2(NUMREG)-1:0]         oISSUE_REGD,
   input  logic                              iISSUE_READY,
   input  logic [NUM_WB-1:0]                 iWB_VALID,
   input  logic [NUM_WB*$clog2(NUMREG)-1:0]  iWB_REG,
   input  logic                              iFLUSH,
   output logic                              oIDLING,
   output logic [$clog2(QDEPTH):0]           oQ_COUNT,
   output logic [NUMREG-1:0]                 oPENDING,
   output logic [15:0]                       oSTALL_CNT
);

   localparam int RBW = $clog2(NUMREG);
   localparam int EW  = DBW + 3*RBW + 3;

   logic [EW-1:0]     push_entry;
   logic [EW-1:0]     head_entry;
   logic              fifo_empty;
   logic [DBW-1:0]    head_instr;
   logic [RBW-1:0]    head_regd;
   logic [RBW-1:0]    head_rega;
   logic [RBW-1:0]    head_regb;
   use_flags_t        head_use;
   logic              hazard;
   logic              issue_valid;
   logic              issue_fire;
   logic              stall_event;
   logic [NUMREG-1:0] pending_q, pending_d;
   logic [15:0]       stall_q, stall_d;

   assign push_entry = {iINSTR, iREGD, iREGA, iREGB, iUSE_D, iUSE_A, iUSE_B};
   assign {head_instr, head_regd, head_rega, head_regb, head_use} = head_entry;

   gppcu_instr_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk        (iACLK),
      .rst        (iRST),
      .flush      (iFLUSH),
      .push_valid (iINSTR_VALID),
      .push_data  (push_entry),
      .push_ready (oINSTR_READY),
      .pop        (issue_fire),
      .head_data  (head_entry),
      .empty      (fifo_empty),
      .count      (oQ_COUNT)
   );

   // Head hazard against the registered scoreboard only: RAW on sources, WAW on dest
   always_comb begin
      hazard = (head_use.use_a & pending_q[head_rega])
             | (head_use.use_b & pending_q[head_regb])
             | (head_use.use_d & pending_q[head_regd]);
   end

   // Issue handshake; reset also suppresses issue so nothing leaves during reset
   always_comb begin
      issue_valid = ~fifo_empty & ~hazard & ~iFLUSH & ~iRST;
      issue_fire  = issue_valid & iISSUE_READY;
      stall_event = ~fifo_empty & hazard & ~iFLUSH;
   end

   // Scoreboard update: writebacks clear first, then an issuing dest sets, so set wins
   always_comb begin
      pending_d = pending_q;
      for (int k = 0; k < NUM_WB; k++) begin
         if (iWB_VALID[k]) pending_d[iWB_REG[k*RBW +: RBW]] = 1'b0;
      end
      if (issue_fire && head_use.use_d) pending_d[head_regd] = 1'b1;
   end

   // Saturating count of cycles the head sat blocked by a hazard
   always_comb begin
      stall_d = stall_q;
      if (stall_event && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
   end

   // Scoreboard and stall counter registers with synchronous reset
   always_ff @(posedge iACLK) begin
      if (iRST) begin
         pending_q <= '0;
         stall_q   <= '0;
      end else begin
         pending_q <= pending_d;
         stall_q   <= stall_d;
      end
   end

   assign oISSUE_VALID = issue_valid;
   assign oISSUE_INSTR = head_instr;
   assign oISSUE_REGD  = head_regd;
   assign oPENDING     = pending_q;
   assign oSTALL_CNT   = stall_q;
   assign oIDLING      = fifo_empty & ~(|pending_q);

endmodule

// File: tb/tb_gppcu_issue_ctrl.sv
// Randomized and directed bench for gppcu_issue_ctrl with a queue-based
// reference model and an issue scoreboard drained by a separate monitor.
module tb_gppcu_issue_ctrl;
   import gppcu_issue_ctrl_pkg::*;

   localparam int DBW    = 32;
   localparam int QDEPTH = 4;
   localparam int NUMREG = 32;
   localparam int NUM_WB = 2;
   localparam int RBW    = 5;

   logic                  iACLK = 1'b0;
   logic                  iRST = 1'b1;
   logic [DBW-1:0]        iINSTR = '0;
   logic                  iINSTR_VALID = 1'b0;
   logic                  oINSTR_READY;
   logic [RBW-1:0]        iREGD = '0, iREGA = '0, iREGB = '0;
   logic                  iUSE_D = 1'b0, iUSE_A = 1'b0, iUSE_B = 1'b0;
   logic                  oISSUE_VALID;
   logic [DBW-1:0]        oISSUE_INSTR;
   logic [RBW-1:0]        oISSUE_REGD;
   logic                  iISSUE_READY = 1'b0;
   logic [NUM_WB-1:0]     iWB_VALID = '0;
   logic [NUM_WB*RBW-1:0] iWB_REG = '0;
   logic                  iFLUSH = 1'b0;
   logic                  oIDLING;
   logic [2:0]            oQ_COUNT;
   logic [NUMREG-1:0]     oPENDING;
   logic [15:0]           oSTALL_CNT;

   typedef struct {
      logic [DBW-1:0] instr;
      logic [RBW-1:0] d, a, b;
      logic           ud, ua, ub;
   } ent_t;

   typedef struct {
      logic [DBW-1:0] instr;
      logic [RBW-1:0] d;
   } exp_t;

   ent_t mq[$];
   bit   pend[NUMREG];
   int   stall_m = 0;
   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   ent_t nop_e;

   always #5 iACLK = ~iACLK;

   gppcu_issue_ctrl #(
      .DBW    (DBW),
      .QDEPTH (QDEPTH),
      .NUMREG (NUMREG),
      .NUM_WB (NUM_WB)
   ) dut (
      .iACLK        (iACLK),
      .iRST         (iRST),
      .iINSTR       (iINSTR),
      .iINSTR_VALID (iINSTR_VALID),
      .oINSTR_READY (oINSTR_READY),
      .iREGD        (iREGD),
      .iREGA        (iREGA),
      .iREGB        (iREGB),
      .iUSE_D       (iUSE_D),
      .iUSE_A       (iUSE_A),
      .iUSE_B       (iUSE_B),
      .oISSUE_VALID (oISSUE_VALID),
      .oISSUE_INSTR (oISSUE_INSTR),
      .oISSUE_REGD  (oISSUE_REGD),
      .iISSUE_READY (iISSUE_READY),
      .iWB_VALID    (iWB_VALID),
      .iWB_REG      (iWB_REG),
      .iFLUSH       (iFLUSH),
      .oIDLING      (oIDLING),
      .oQ_COUNT     (oQ_COUNT),
      .oPENDING     (oPENDING),
      .oSTALL_CNT   (oSTALL_CNT)
   );

   // One comparison: counts it, and reports it if the DUT value differs
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ent_t mkEnt(input logic [RBW-1:0] d, a, b, input logic ud, ua, ub);
      ent_t e;
      e.instr = insert_fields(DBW'($urandom), d, a, b);
      e.d = d; e.a = a; e.b = b;
      e.ud = ud; e.ua = ua; e.ub = ub;
      return e;
   endfunction

   // Drives one cycle of inputs, checks DUT outputs against the model, then
   // advances the model across the coming clock edge
   task automatic applyStimulus(input logic rst, input logic inv, input ent_t e,
                                input logic iss_rdy, input logic [1:0] wbv,
                                input logic [RBW-1:0] wb0, input logic [RBW-1:0] wb1,
                                input logic fl);
      int          cnt;
      bit          hz, vld, fire;
      logic [31:0] pv;
      exp_t        x;
      @(negedge iACLK);
      iRST = rst;
      iINSTR_VALID = inv;
      iINSTR = e.instr;
      iREGD = e.d; iREGA = e.a; iREGB = e.b;
      iUSE_D = e.ud; iUSE_A = e.ua; iUSE_B = e.ub;
      iISSUE_READY = iss_rdy;
      iWB_VALID = wbv;
      iWB_REG = {wb1, wb0};
      iFLUSH = fl;
      #1;
      cnt = mq.size();
      hz = 1'b0;
      if (cnt > 0)
         hz = (mq[0].ua && pend[mq[0].a]) || (mq[0].ub && pend[mq[0].b]) || (mq[0].ud && pend[mq[0].d]);
      vld = (cnt > 0) && !hz && !fl && !rst;
      pv = '0;
      for (int i = 0; i < NUMREG; i++) pv[i] = pend[i];
      checkOutput("instr_ready", 64'(oINSTR_READY), 64'(cnt < QDEPTH));
      checkOutput("q_count", 64'(oQ_COUNT), 64'(cnt));
      checkOutput("issue_valid", 64'(oISSUE_VALID), 64'(vld));
      checkOutput("pending", 64'(oPENDING), 64'(pv));
      checkOutput("stall_cnt", 64'(oSTALL_CNT), 64'(stall_m));
      checkOutput("idling", 64'(oIDLING), 64'((cnt == 0) && (pv == 0)));
      if (cnt > 0) checkOutput("head_regd", 64'(oISSUE_REGD), 64'(mq[0].d));
      fire = vld && iss_rdy;
      if (fire) begin
         x.instr = mq[0].instr;
         x.d = mq[0].d;
         exp_q.push_back(x);
      end
      if (rst) begin
         mq.delete();
         for (int i = 0; i < NUMREG; i++) pend[i] = 1'b0;
         stall_m = 0;
      end else begin
         if (cnt > 0 && hz && !fl && stall_m < 65535) stall_m++;
         if (wbv[0]) pend[wb0] = 1'b0;
         if (wbv[1]) pend[wb1] = 1'b0;
         if (fire && mq[0].ud) pend[mq[0].d] = 1'b1;
         if (fl) mq.delete();
         else begin
            if (fire) void'(mq.pop_front());
            if (inv && cnt < QDEPTH) mq.push_back(e);
         end
      end
   endtask

   task automatic idleCycles(input int n, input logic iss_rdy);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, nop_e, iss_rdy, 2'b00, '0, '0, 1'b0);
   endtask

   task automatic pushOne(input ent_t e, input logic iss_rdy);
      applyStimulus(1'b0, 1'b1, e, iss_rdy, 2'b00, '0, '0, 1'b0);
   endtask

   task automatic writeBack(input logic [1:0] wbv, input logic [RBW-1:0] r0, input logic [RBW-1:0] r1,
                            input logic iss_rdy);
      applyStimulus(1'b0, 1'b0, nop_e, iss_rdy, wbv, r0, r1, 1'b0);
   endtask

   // Monitor: whenever the DUT completes an issue handshake, pop the expected entry
   initial begin
      exp_t x;
      forever begin
         @(negedge iACLK);
         #2;
         if (oISSUE_VALID && iISSUE_READY) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_issue: got instr %0h expected no issue at %0t", oISSUE_INSTR, $time);
            end else begin
               x = exp_q.pop_front();
               checkOutput("issue_instr", 64'(oISSUE_INSTR), 64'(x.instr));
               checkOutput("issue_regd", 64'(oISSUE_REGD), 64'(x.d));
            end
         end
      end
   end

   initial begin
      ent_t e;
      nop_e = mkEnt('0, '0, '0, 1'b0, 1'b0, 1'b0);

      // Reset state
      applyStimulus(1'b1, 1'b0, nop_e, 1'b0, 2'b00, '0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, nop_e, 1'b0, 2'b00, '0, '0, 1'b0);
      idleCycles(1, 1'b0);

      // Fill the queue with independent entries; a fifth is held off
      for (int i = 0; i < 5; i++) pushOne(mkEnt(RBW'(10 + i), RBW'(20), RBW'(21), 1'b1, 1'b0, 1'b0), 1'b0);
      idleCycles(1, 1'b0);
      checkOutput("full_count", 64'(oQ_COUNT), 64'd4);
      checkOutput("full_ready", 64'(oINSTR_READY), 64'd0);
      idleCycles(6, 1'b1);
      writeBack(2'b11, RBW'(10), RBW'(11), 1'b1);
      writeBack(2'b11, RBW'(12), RBW'(13), 1'b1);
      idleCycles(1, 1'b1);

      // RAW stall on r3 released one cycle after the writeback edge
      pushOne(mkEnt(RBW'(3), RBW'(1), RBW'(2), 1'b1, 1'b1, 1'b1), 1'b1);
      pushOne(mkEnt(RBW'(4), RBW'(3), RBW'(0), 1'b1, 1'b1, 1'b0), 1'b1);
      idleCycles(5, 1'b1);
      writeBack(2'b01, RBW'(3), RBW'(0), 1'b1);
      idleCycles(3, 1'b1);
      writeBack(2'b10, RBW'(0), RBW'(4), 1'b1);

      // Issue of r7 and writeback of r7 on the same edge leaves r7 pending
      pushOne(mkEnt(RBW'(7), RBW'(1), RBW'(1), 1'b1, 1'b0, 1'b0), 1'b0);
      writeBack(2'b01, RBW'(7), RBW'(0), 1'b1);
      idleCycles(1, 1'b1);
      checkOutput("set_wins", 64'(oPENDING[7]), 64'd1);

      // Both writeback ports clear r2 and r5 on the same edge
      pushOne(mkEnt(RBW'(2), RBW'(0), RBW'(0), 1'b1, 1'b0, 1'b0), 1'b1);
      pushOne(mkEnt(RBW'(5), RBW'(0), RBW'(0), 1'b1, 1'b0, 1'b0), 1'b1);
      idleCycles(2, 1'b1);
      writeBack(2'b11, RBW'(2), RBW'(5), 1'b1);
      idleCycles(1, 1'b1);

      // Flush with three queued and an enqueue attempt; r7 stays pending
      for (int i = 0; i < 3; i++) pushOne(mkEnt(RBW'(20 + i), RBW'(8), RBW'(9), 1'b1, 1'b1, 1'b1), 1'b0);
      e = mkEnt(RBW'(23), RBW'(0), RBW'(0), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, e, 1'b1, 2'b00, '0, '0, 1'b1);
      idleCycles(2, 1'b1);
      writeBack(2'b01, RBW'(7), RBW'(0), 1'b1);

      // Randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 2000; n++) begin
         e = mkEnt(RBW'($urandom_range(7, 0)), RBW'($urandom_range(7, 0)), RBW'($urandom_range(7, 0)),
                   1'($urandom), 1'($urandom), 1'($urandom));
         applyStimulus(1'($urandom_range(199, 0) == 0), 1'($urandom_range(99, 0) < 70), e,
                       1'($urandom_range(99, 0) < 70),
                       2'($urandom_range(3, 0)), RBW'($urandom_range(7, 0)), RBW'($urandom_range(7, 0)),
                       1'($urandom_range(99, 0) < 3));
      end

      // Long hazard stall drives the counter into saturation, then reset clears it
      applyStimulus(1'b1, 1'b0, nop_e, 1'b0, 2'b00, '0, '0, 1'b0);
      pushOne(mkEnt(RBW'(9), RBW'(0), RBW'(0), 1'b1, 1'b0, 1'b0), 1'b1);
      pushOne(mkEnt(RBW'(1), RBW'(9), RBW'(0), 1'b1, 1'b1, 1'b0), 1'b1);
      idleCycles(65600, 1'b1);
      checkOutput("stall_saturated", 64'(oSTALL_CNT), 64'hFFFF);
      applyStimulus(1'b1, 1'b0, nop_e, 1'b0, 2'b00, '0, '0, 1'b0);
      idleCycles(1, 1'b0);
      checkOutput("stall_after_reset", 64'(oSTALL_CNT), 64'd0);
      checkOutput("idle_after_reset", 64'(oIDLING), 64'd1);
      idleCycles(1, 1'b0);

      checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gppcu_issue_ctrl.md
GPPCU_ISSUE_CTRL -- requirements
Module: gppcu_issue_ctrl

Interface
REQ-001 SHALL have parameter DBW, default 32, instruction word width.
REQ-002 SHALL have parameter QDEPTH, default 4, instruction queue depth (power of two, 2..16).
REQ-003 SHALL have parameter NUMREG, default 32, scoreboard register count; RBW = clog2(NUMREG).
REQ-004 SHALL have parameter NUM_WB, default 2, count of independent writeback ports.
REQ-005 SHALL have one clock and a synchronous, active-high reset: iACLK, iRST.
REQ-006 Ports: iACLK in 1 clock; iRST in 1 sync active-high reset.
REQ-007 iINSTR in DBW, instruction payload; iINSTR_VALID in 1; oINSTR_READY out 1, queue not full.
REQ-008 iREGD/iREGA/iREGB in RBW each, register fields; iUSE_D/iUSE_A/iUSE_B in 1 each, field-valid flags, all captured with iINSTR.
REQ-009 oISSUE_VALID out 1; oISSUE_INSTR out DBW; oISSUE_REGD out RBW; iISSUE_READY in 1, execute stage can accept.
REQ-010 iWB_VALID in NUM_WB; iWB_REG in NUM_WB*RBW, port k at bits [k*RBW +: RBW].
REQ-011 iFLUSH in 1, discard queued instructions.
REQ-012 oIDLING out 1; oQ_COUNT out clog2(QDEPTH)+1; oPENDING out NUMREG, scoreboard bits; oSTALL_CNT out 16, hazard-stall cycles.

Function
REQ-013 Enqueue SHALL occur on a rising edge when iINSTR_VALID & oINSTR_READY; payload, fields and flags stored together.
REQ-014 oINSTR_READY SHALL equal (oQ_COUNT < QDEPTH) and SHALL NOT depend on same-cycle dequeue; full queue deasserts ready.
REQ-015 No empty-queue bypass: an entry enqueued at edge N is presentable at issue no earlier than cycle after edge N.
REQ-016 Hazard for head entry = (iUSE_A & pending[REGA]) | (iUSE_B & pending[REGB]) | (iUSE_D & pending[REGD]) (RAW and WAW), using registered scoreboard only, no writeback bypass.
REQ-017 oISSUE_VALID SHALL be combinational: queue non-empty & ~hazard & ~iFLUSH; oISSUE_INSTR/oISSUE_REGD always show head entry.
REQ-018 Issue (dequeue) SHALL occur on an edge when oISSUE_VALID & iISSUE_READY; if head iUSE_D, pending[REGD] set at that edge.
REQ-019 Each edge, for each k with iWB_VALID[k], pending[iWB_REG[k]] SHALL clear; multiple ports same register clears once.
REQ-020 Same-edge issue set and writeback clear of one register: set SHALL win (bit remains 1).
REQ-021 Head blocked one cycle by a register cleared that edge SHALL issue the following cycle earliest (1-cycle WB-to-issue latency).
REQ-022 Simultaneous enqueue and dequeue SHALL keep oQ_COUNT unchanged; pointers wrap modulo QDEPTH.
REQ-023 iFLUSH at an edge SHALL empty queue (count 0, pointers reset); enqueue that edge ignored; scoreboard untouched.
REQ-024 oSTALL_CNT SHALL increment by 1 each edge with queue non-empty & hazard & ~iFLUSH, saturating at 16'hFFFF.
REQ-025 oIDLING SHALL be 1 when queue empty and all pending bits 0.

Reset
REQ-026 iRST sampled high at an edge SHALL clear queue, pointers, count, all pending bits, oSTALL_CNT; overrides enqueue, issue, writeback and flush that edge.
REQ-027 Output values during/after reset: oINSTR_READY=1, oISSUE_VALID=0, oQ_COUNT=0, oPENDING=0, oSTALL_CNT=0, oIDLING=1; oISSUE_INSTR don't-care.
REQ-028 Reset mid-operation SHALL discard in-flight queue entries; later writebacks to cleared registers are harmless.

Structure
REQ-029 Shared package header SHALL hold instruction field offsets (REGD/REGA/REGB positions) and default DBW/RBW constants, consistent with core parameter header.
REQ-030 Queue SHALL be a sub-module gppcu_instr_fifo (DEPTH, WIDTH params, count output, flush input); scoreboard and stall counter live in top.

Verification
REQ-031 Reset, push 4 independent instrs (QDEPTH=4), iISSUE_READY=0 -> oQ_COUNT=4, oINSTR_READY=0; 5th held.
REQ-032 Issue D=r3, then head A=r3 -> oISSUE_VALID=0, oSTALL_CNT counts; iWB_REG=3 -> issue exactly one cycle after WB edge.
REQ-033 Head D=r7 issues same edge as iWB_VALID on r7 -> oPENDING[7]=1 afterwards.
REQ-034 Both WB ports write r2 and r5 same edge with r2,r5 pending -> both bits 0 next cycle.
REQ-035 Queue count 3 plus iFLUSH with iINSTR_VALID=1 -> count 0, no issue that cycle, pending bits unchanged.
REQ-036 Stall held 70000 cycles -> oSTALL_CNT=16'hFFFF and stays; iRST -> 0, oIDLING=1.
